// File: rtl/uart_pkg.sv
// Shared constants and write-handshake state type for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W  = 8;
  localparam int unsigned UART_ENTRY_W = UART_DATA_W + 1;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wr_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x {frame_err, data} register array: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [UART_ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic [UART_ENTRY_W-1:0] rdata
);

  logic [UART_ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART engine: push/ack handshake, FWFT read port, status and IRQ.
// Optional idle-timeout interrupt enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned IRQ_THRESH = 1
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_fifo_rq,
  input  logic [UART_DATA_W-1:0] i_rx_data,
  input  logic                   i_frame_err,
  output logic                   o_rx_finish,
  input  logic                   i_rd_en,
  output logic [UART_DATA_W-1:0] o_rd_data,
  output logic                   o_rd_ferr,
  input  logic                   i_clr,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [AW:0]            o_count,
  output logic                   o_overflow,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  output logic                   o_timeout,
`endif
  output logic                   o_irq
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [AW:0] THRESH_C = CW'(IRQ_THRESH);

  wr_state_e               state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q, count_d;
  logic                    empty_q, full_q, ovf_q, irq_q;
  logic [UART_ENTRY_W-1:0] head_q, mem_rdata;
  logic                    push_req, push_ok, pop, drop;

  assign push_req = (state_q == W_IDLE) && i_fifo_rq;
  assign pop      = i_rd_en && !empty_q;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_ok  = push_req && (!full_q || pop) && !i_clr;
  assign drop     = push_req && full_q && !pop;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata ({i_frame_err, i_rx_data}),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    o_rx_finish = 1'b0;
    case (state_q)
      W_IDLE: if (i_fifo_rq) state_d = W_ACK;
      W_ACK: begin
        o_rx_finish = 1'b1;
        state_d     = W_IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (i_clr)               count_d = '0;
    else if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= W_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      state_q <= state_d;
      if (i_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        if (drop)    ovf_q    <= 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_C);
      irq_q   <= (count_q >= THRESH_C) | ovf_q;
      // Remember the last visible head so the read port holds it once empty.
      if (!empty_q) head_q <= mem_rdata;
    end
  end

  assign o_rd_data  = empty_q ? head_q[UART_DATA_W-1:0] : mem_rdata[UART_DATA_W-1:0];
  assign o_rd_ferr  = empty_q ? head_q[UART_DATA_W]     : mem_rdata[UART_DATA_W];
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [31:0] idle_cnt_q;
  logic        tmo_q;
  logic        idle_clr;

  assign idle_clr = push_req || pop || i_clr || empty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else if (idle_clr) begin
      idle_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else if (idle_cnt_q == TIMEOUT_CYCLES - 1) begin
      tmo_q <= 1'b1;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign o_timeout = tmo_q;
  assign o_irq     = irq_q | tmo_q;
`else
  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo; covers UART_RX_FIFO_TIMEOUT_EN when defined.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int THRESH = 4;
`else
  localparam int THRESH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i_fifo_rq, i_frame_err, i_rd_en, i_clr;
  logic [7:0] i_rx_data;
  logic       o_rx_finish, o_rd_ferr, o_empty, o_full, o_overflow, o_irq;
  logic [7:0] o_rd_data;
  logic [4:0] o_count;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic       o_timeout;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [8:0]  sb[$];
  logic        movf;
  logic [8:0]  last_head;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH      (DEPTH),
    .IRQ_THRESH (THRESH)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (32'd10)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_fifo_rq   (i_fifo_rq),
    .i_rx_data   (i_rx_data),
    .i_frame_err (i_frame_err),
    .o_rx_finish (o_rx_finish),
    .i_rd_en     (i_rd_en),
    .o_rd_data   (o_rd_data),
    .o_rd_ferr   (o_rd_ferr),
    .i_clr       (i_clr),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .o_timeout   (o_timeout),
`endif
    .o_irq       (o_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    tick();
    chk({tag, "_count"}, 32'(o_count), 32'(sb.size()));
    chk({tag, "_empty"}, 32'(o_empty), 32'(sb.size() == 0));
    chk({tag, "_full"},  32'(o_full),  32'(sb.size() == DEPTH));
    chk({tag, "_ovf"},   32'(o_overflow), 32'(movf));
    chk({tag, "_irq"},   32'(o_irq), 32'((sb.size() >= THRESH) || movf));
    if (sb.size() != 0) chk({tag, "_head"}, {23'd0, o_rd_ferr, o_rd_data}, 32'(sb[0]));
    else                chk({tag, "_hold"}, {23'd0, o_rd_ferr, o_rd_data}, 32'(last_head));
  endtask

  task automatic push(input logic [7:0] d, input logic fe);
    i_fifo_rq   = 1'b1;
    i_rx_data   = d;
    i_frame_err = fe;
    tick();
    i_fifo_rq   = 1'b0;
    i_frame_err = 1'b0;
    chk("finish_hi", 32'(o_rx_finish), 32'd1);
    if (sb.size() < DEPTH) sb.push_back({fe, d});
    else                   movf = 1'b1;
    tick();
    chk("finish_lo", 32'(o_rx_finish), 32'd0);
  endtask

  task automatic pop();
    logic [8:0] exp;
    chk("pop_nonempty", 32'(o_empty), 32'd0);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      chk("pop_data", 32'(o_rd_data), 32'(exp[7:0]));
      chk("pop_ferr", 32'(o_rd_ferr), 32'(exp[8]));
      last_head = exp;
    end
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] d);
    logic [8:0] exp;
    exp = sb.pop_front();
    chk("pp_head", {23'd0, o_rd_ferr, o_rd_data}, 32'(exp));
    i_fifo_rq = 1'b1;
    i_rx_data = d;
    i_rd_en   = 1'b1;
    tick();
    i_fifo_rq = 1'b0;
    i_rd_en   = 1'b0;
    chk("pp_finish_hi", 32'(o_rx_finish), 32'd1);
    sb.push_back({1'b0, d});
    tick();
    chk("pp_finish_lo", 32'(o_rx_finish), 32'd0);
  endtask

  task automatic model_clear();
    if (sb.size() != 0) last_head = sb[0];
    sb.delete();
    movf = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_fifo_rq = 1'b0; i_rx_data = '0; i_frame_err = 1'b0;
    i_rd_en = 1'b0; i_clr = 1'b0;
    movf = 1'b0; last_head = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",  32'(o_empty), 32'd1);
    chk("rst_full",   32'(o_full), 32'd0);
    chk("rst_count",  32'(o_count), 32'd0);
    chk("rst_ovf",    32'(o_overflow), 32'd0);
    chk("rst_irq",    32'(o_irq), 32'd0);
    chk("rst_rdata",  32'(o_rd_data), 32'd0);
    chk("rst_rferr",  32'(o_rd_ferr), 32'd0);
    chk("rst_finish", 32'(o_rx_finish), 32'd0);
    rst = 1'b0;

    // Single byte
    push(8'hA5, 1'b0);
    check_status("single");
    pop();
    check_status("single_drained");

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check_status("filled");
    push(8'hFF, 1'b0);
    check_status("overflow");
    for (int i = 0; i < DEPTH; i++) pop();
    check_status("drained");

    // Clear sticky overflow, refill, simultaneous push/pop at full
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    model_clear();
    check_status("cleared");
    for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i), 1'b0);
    push_pop(8'h99);
    check_status("pp_full");
    for (int i = 0; i < DEPTH; i++) pop();
    chk("pp_last_byte", 32'(last_head), 32'h099);
    check_status("pp_drained");

    // Frame errors with pointer wrap
    for (int i = 0; i < 20; i++) begin
      push(8'h60 + 8'(i), (i == 3) || (i == 17));
      if (i % 2 == 1) pop();
    end
    while (sb.size() != 0) pop();
    check_status("wrap_drained");
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    check_status("pop_on_empty");

    // Clear coinciding with a push, while overflowed
    for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i), 1'b0);
    push(8'hEE, 1'b0);
    check_status("pre_clr");
    i_clr = 1'b1; i_fifo_rq = 1'b1; i_rx_data = 8'h55;
    tick();
    i_clr = 1'b0; i_fifo_rq = 1'b0;
    model_clear();
    chk("clr_finish_hi", 32'(o_rx_finish), 32'd1);
    chk("clr_count",     32'(o_count), 32'd0);
    chk("clr_ovf",       32'(o_overflow), 32'd0);
    tick();
    chk("clr_finish_lo", 32'(o_rx_finish), 32'd0);
    check_status("post_clr");

    // Reset during the acknowledge cycle
    i_fifo_rq = 1'b1; i_rx_data = 8'h11;
    tick();
    i_fifo_rq = 1'b0;
    chk("rstack_finish_hi", 32'(o_rx_finish), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstack_finish_lo", 32'(o_rx_finish), 32'd0);
    chk("rstack_count",     32'(o_count), 32'd0);
    tick();
    rst = 1'b0;
    sb.delete(); movf = 1'b0; last_head = '0;
    check_status("post_rst");
    push(8'h22, 1'b1);
    check_status("post_rst_push");
    pop();
    check_status("post_rst_pop");

`ifdef UART_RX_FIFO_TIMEOUT_EN
    push(8'h33, 1'b0);
    repeat (8) tick();
    chk("tmo_before", 32'(o_timeout), 32'd0);
    tick();
    chk("tmo_set",     32'(o_timeout), 32'd1);
    chk("tmo_irq_set", 32'(o_irq), 32'd1);
    pop();
    chk("tmo_clr",     32'(o_timeout), 32'd0);
    chk("tmo_irq_clr", 32'(o_irq), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
